// File: rtl/reduce_logic_unit.sv
// Pipelined per-channel logic reduction (AND/OR/XOR/NAND/NOR/XNOR) feeding a valid/ready FIFO.
// Optional majority op enabled by defining RLU_MAJ_EN; otherwise op 6 reports err like op 7.
module reduce_logic_unit #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CH    = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [CH*WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH-1:0]         out_data,
    output logic [2:0]            out_op,
    output logic                  out_err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    localparam logic [2:0] OpAnd  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpXor  = 3'd2;
    localparam logic [2:0] OpNand = 3'd3;
    localparam logic [2:0] OpNor  = 3'd4;
    localparam logic [2:0] OpXnor = 3'd5;
    localparam logic [2:0] OpMaj  = 3'd6;
    localparam logic [2:0] OpRsvd = 3'd7;

`ifdef RLU_MAJ_EN
    // Strict majority: an even-WIDTH tie resolves to 0.
    function automatic logic maj_bit(input logic [WIDTH-1:0] g);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + {31'd0, g[i]};
        end
        return ((32'd2 * ones) > WIDTH);
    endfunction
`endif

    // Reduction datapath
    logic [CH-1:0]    res;
    logic [WIDTH-1:0] grp;
    logic             op_err;

`ifdef RLU_MAJ_EN
    assign op_err = (in_op == OpRsvd);
`else
    assign op_err = (in_op == OpRsvd) || (in_op == OpMaj);
`endif

    always_comb begin
        res = '0;
        grp = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            grp = in_data[k*WIDTH +: WIDTH];
            case (in_op)
                OpAnd:   res[k] = &grp;
                OpOr:    res[k] = |grp;
                OpXor:   res[k] = ^grp;
                OpNand:  res[k] = ~&grp;
                OpNor:   res[k] = ~|grp;
                OpXnor:  res[k] = ~^grp;
`ifdef RLU_MAJ_EN
                OpMaj:   res[k] = maj_bit(grp);
`endif
                default: res[k] = 1'b0;
            endcase
        end
    end

    // Output FIFO
    logic [CH-1:0]   mem_data [DEPTH];
    logic [2:0]      mem_op   [DEPTH];
    logic            mem_err  [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] head_ptr;
    logic [CntW-1:0] count;
    logic            push;
    logic            pop;

    assign in_ready  = rst_n && (count != FullCnt);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When empty, the slot behind rd_ptr still holds the last popped entry (or reset zeros).
    assign head_ptr  = out_valid ? rd_ptr : (rd_ptr - PtrW'(1));
    assign out_data  = mem_data[head_ptr];
    assign out_op    = mem_op[head_ptr];
    assign out_err   = mem_err[head_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_op[i]   <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= res;
                mem_op[wr_ptr]   <= in_op;
                mem_err[wr_ptr]  <= op_err;
                wr_ptr           <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_logic_unit.sv
// Directed self-checking bench for reduce_logic_unit: one 3x1 depth-2 instance, one 4x2 depth-4.
module tb_reduce_logic_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [2:0] a_in_op, a_out_op;
    logic [2:0] a_in_data;
    logic [0:0] a_out_data;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [2:0] b_in_op, b_out_op;
    logic [7:0] b_in_data;
    logic [1:0] b_out_data;

    reduce_logic_unit #(.WIDTH(3), .CH(1), .DEPTH(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_op     (a_in_op),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_op    (a_out_op),
        .out_err   (a_out_err)
    );

    reduce_logic_unit #(.WIDTH(4), .CH(2), .DEPTH(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_op     (b_in_op),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_op    (b_out_op),
        .out_err   (b_out_err)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push/pop streaming table: op, 3-bit data, expected result.
    logic [2:0] pp_op  [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd3, 3'd5, 3'd0, 3'd1};
    logic [2:0] pp_dat [11] = '{3'b111, 3'b000, 3'b011, 3'b111, 3'b000, 3'b100,
                                3'b111, 3'b101, 3'b110, 3'b110, 3'b010};
    logic       pp_exp [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Ops 0..5 on in_data = 8'b1111_0110.
    logic [1:0] exp_b [6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11};

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_op = '0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_op = '0; b_in_data = '0; b_out_ready = 1'b0;
        step();
        step();

        check("rst_in_ready_a",  32'(a_in_ready),  32'd0);
        check("rst_in_ready_b",  32'(b_in_ready),  32'd0);
        check("rst_out_valid_a", 32'(a_out_valid), 32'd0);
        check("rst_out_data_a",  32'(a_out_data),  32'd0);
        check("rst_out_op_a",    32'(a_out_op),    32'd0);
        check("rst_out_err_a",   32'(a_out_err),   32'd0);
        check("rst_out_data_b",  32'(b_out_data),  32'd0);

        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Exhaustive OR / NOR, consumer always ready
        a_out_ready = 1'b1;
        for (int o = 0; o < 2; o++) begin
            for (int d = 0; d < 8; d++) begin
                a_in_valid = 1'b1;
                a_in_op    = (o == 0) ? 3'd1 : 3'd4;
                a_in_data  = 3'(d);
                step();
                check("orn_valid", 32'(a_out_valid), 32'd1);
                check("orn_data",  32'(a_out_data),
                      (o == 0) ? 32'(d != 0) : 32'(d == 0));
                check("orn_op",    32'(a_out_op), (o == 0) ? 32'd1 : 32'd4);
                check("orn_err",   32'(a_out_err), 32'd0);
                check("orn_ready", 32'(a_in_ready), 32'd1);
            end
        end
        a_in_valid = 1'b0;
        step();
        check("empty_valid",   32'(a_out_valid), 32'd0);
        check("empty_hold_op", 32'(a_out_op),    32'd4);

        // Full FIFO back-pressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_op = 3'd0; a_in_data = 3'b111;
        step();
        check("full_first_valid", 32'(a_out_valid), 32'd1);
        check("full_first_ready", 32'(a_in_ready),  32'd1);
        a_in_op = 3'd2; a_in_data = 3'b001;
        step();
        check("full_ready_low", 32'(a_in_ready), 32'd0);
        a_in_op = 3'd4; a_in_data = 3'b000;
        step();
        step();
        check("full_stall_ready", 32'(a_in_ready), 32'd0);
        check("full_stall_op",    32'(a_out_op),   32'd0);
        check("full_stall_data",  32'(a_out_data), 32'd1);
        a_out_ready = 1'b1;
        step();
        check("drain1_op",    32'(a_out_op),   32'd2);
        check("drain1_data",  32'(a_out_data), 32'd1);
        check("drain1_ready", 32'(a_in_ready), 32'd1);
        step();
        check("drain2_valid", 32'(a_out_valid), 32'd1);
        check("drain2_op",    32'(a_out_op),    32'd4);
        check("drain2_data",  32'(a_out_data),  32'd1);
        a_in_valid = 1'b0;
        step();
        check("drain3_empty", 32'(a_out_valid), 32'd0);

        // One entry resident, simultaneous push/pop across pointer wrap
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_op = pp_op[0]; a_in_data = pp_dat[0];
        step();
        check("pp_pre_op", 32'(a_out_op), 32'(pp_op[0]));
        a_out_ready = 1'b1;
        for (int i = 1; i < 11; i++) begin
            a_in_op = pp_op[i]; a_in_data = pp_dat[i];
            step();
            check("pp_valid", 32'(a_out_valid), 32'd1);
            check("pp_op",    32'(a_out_op),    32'(pp_op[i]));
            check("pp_data",  32'(a_out_data),  32'(pp_exp[i]));
            check("pp_ready", 32'(a_in_ready),  32'd1);
        end
        a_in_valid = 1'b0;
        step();
        check("pp_empty", 32'(a_out_valid), 32'd0);

        // Reserved op and op 6
        a_in_valid = 1'b1; a_in_op = 3'd7; a_in_data = 3'b111;
        step();
        check("op7_data", 32'(a_out_data), 32'd0);
        check("op7_err",  32'(a_out_err),  32'd1);
        check("op7_op",   32'(a_out_op),   32'd7);
        a_in_op = 3'd6; a_in_data = 3'b110;
        step();
`ifdef RLU_MAJ_EN
        check("op6_data", 32'(a_out_data), 32'd1);
        check("op6_err",  32'(a_out_err),  32'd0);
`else
        check("op6_data", 32'(a_out_data), 32'd0);
        check("op6_err",  32'(a_out_err),  32'd1);
`endif
        a_in_op = 3'd1; a_in_data = 3'b001;
        step();
        check("err_clear", 32'(a_out_err), 32'd0);
        a_in_valid = 1'b0;
        step();

        // Reset with two entries queued and a handshake pending
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_op = 3'd1; a_in_data = 3'b001;
        step();
        a_in_op = 3'd5; a_in_data = 3'b000;
        step();
        check("mrst_full", 32'(a_in_ready), 32'd0);
        rst_n = 1'b0;
        a_out_ready = 1'b1;
        a_in_op = 3'd2; a_in_data = 3'b001;
        #1;
        check("mrst_ready_low", 32'(a_in_ready), 32'd0);
        step();
        check("mrst_valid", 32'(a_out_valid), 32'd0);
        check("mrst_data",  32'(a_out_data),  32'd0);
        check("mrst_op",    32'(a_out_op),    32'd0);
        check("mrst_err",   32'(a_out_err),   32'd0);
        rst_n = 1'b1;
        a_out_ready = 1'b0;
        a_in_op = 3'd1; a_in_data = 3'b010;
        step();
        check("mrst_new_valid", 32'(a_out_valid), 32'd1);
        check("mrst_new_op",    32'(a_out_op),    32'd1);
        check("mrst_new_data",  32'(a_out_data),  32'd1);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        step();
        check("mrst_no_stale", 32'(a_out_valid), 32'd0);

        // Two-channel op table
        b_out_ready = 1'b1;
        for (int o = 0; o < 6; o++) begin
            b_in_valid = 1'b1; b_in_op = 3'(o); b_in_data = 8'b1111_0110;
            step();
            check("b_op_data", 32'(b_out_data), 32'(exp_b[o]));
            check("b_op_op",   32'(b_out_op),   32'(o));
        end
        b_in_op = 3'd6; b_in_data = 8'b1110_0110;
        step();
`ifdef RLU_MAJ_EN
        check("b_maj_data", 32'(b_out_data), 32'd2);
        check("b_maj_err",  32'(b_out_err),  32'd0);
`else
        check("b_maj_data", 32'(b_out_data), 32'd0);
        check("b_maj_err",  32'(b_out_err),  32'd1);
`endif
        b_in_valid = 1'b0;
        step();

        // Depth-4 fill and ordered drain
        b_out_ready = 1'b0;
        for (int o = 0; o < 4; o++) begin
            b_in_valid = 1'b1; b_in_op = 3'(o); b_in_data = 8'b1111_0110;
            step();
            check("b_fill_ready", 32'(b_in_ready), (o < 3) ? 32'd1 : 32'd0);
        end
        b_in_op = 3'd5;
        step();
        check("b_full_ready", 32'(b_in_ready), 32'd0);
        check("b_full_head",  32'(b_out_op),   32'd0);
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            check("b_drain_op",   32'(b_out_op),   32'(o));
            check("b_drain_data", 32'(b_out_data), 32'(exp_b[o]));
            step();
        end
        check("b_drain_empty", 32'(b_out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
